// File: rtl/train_pkg.sv
// Shared types for the train-departure feasibility chain.
// Holds state encoding, size defaults and the car-index type.
package train_pkg;

  localparam int MAX_CARS_DEF = 10;
  localparam int DATA_W_DEF   = 4;
  localparam int WD_CYCLES    = 32;

  typedef logic [DATA_W_DEF-1:0] car_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    SEND,
    WAIT,
    REPORT
  } state_e;

endpackage

// File: rtl/train_seq_feeder_if.sv
// Host-side beat stream into the sequence feeder.
// Valid/ready handshake with a frame-end marker.
interface train_seq_feeder_if #(
  parameter int DATA_W = train_pkg::DATA_W_DEF
);

  logic              host_valid;
  logic              host_ready;
  logic [DATA_W-1:0] host_data;
  logic              host_last;

  modport master (
    output host_valid,
    output host_data,
    output host_last,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_data,
    input  host_last,
    output host_ready
  );

endinterface

// File: rtl/train_seq_validator.sv
// Incremental permutation check over a seen bitmap:
// range, duplicate and completeness against the final count.
module train_seq_validator #(
  parameter int MAX_CARS = 10,
  parameter int DATA_W   = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat,
  input  logic [DATA_W-1:0] value,
  input  logic [CNT_W-1:0]  count,
  output logic              err
);

  logic [MAX_CARS-1:0] seen_q, seen_d;
  logic                bad_q, bad_d;
  logic [MAX_CARS-1:0] mask;
  logic [DATA_W-1:0]   pos;

  assign pos = value - 1'b1;

  always_comb begin
    seen_d = seen_q;
    bad_d  = bad_q;
    if (clear) begin
      seen_d = '0;
      bad_d  = 1'b0;
    end else if (beat) begin
      if (value == '0 || value > DATA_W'(MAX_CARS))
        bad_d = 1'b1;
      else if (seen_q[pos])
        bad_d = 1'b1;
      else
        seen_d[pos] = 1'b1;
    end
  end

  // bit v-1 stands for car v, so a full set is the low count bits
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_CARS; i++)
      mask[i] = (i < int'(count));
  end

  assign err = bad_q | (seen_q != mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      bad_q  <= bad_d;
    end
  end

endmodule

// File: rtl/train_seq_feeder.sv
// Buffers a departure sequence, validates it, replays it to the checker.
// Define FEEDER_WATCHDOG_EN to bound the wait for the checker verdict.
module train_seq_feeder
  import train_pkg::*;
#(
  parameter int MAX_CARS = MAX_CARS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  train_seq_feeder_if.slave  host,
  output logic               in_valid,
  output logic [DATA_W-1:0]  data,
  input  logic               chk_out_valid,
  input  logic               chk_result,
  output logic               done_valid,
  output logic               done_result,
  output logic               done_err
);

  localparam int CNT_W = $clog2(MAX_CARS + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CARS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q [MAX_CARS];
  logic [DATA_W-1:0] buf_d [MAX_CARS];
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic              in_valid_q, in_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_valid_q, done_valid_d;
  logic              done_result_q, done_result_d;
  logic              done_err_q, done_err_d;
  logic              beat, v_beat, v_clr, v_err;
`ifdef FEEDER_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0]   wd_q, wd_d;
`endif

  assign host.host_ready = (state_q == IDLE) || (state_q == LOAD);
  assign beat = host.host_valid && host.host_ready;

  train_seq_validator #(
    .MAX_CARS (MAX_CARS),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W)
  ) u_val (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (v_clr),
    .beat  (v_beat),
    .value (host.host_data),
    .count (cnt_q),
    .err   (v_err)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    ovf_d         = ovf_q;
    perr_d        = perr_q;
    in_valid_d    = 1'b0;
    data_d        = '0;
    done_valid_d  = 1'b0;
    done_result_d = 1'b0;
    done_err_d    = 1'b0;
    v_beat        = 1'b0;
    v_clr         = 1'b0;
`ifdef FEEDER_WATCHDOG_EN
    wd_d          = wd_q;
`endif
    case (state_q)
      IDLE, LOAD: begin
        if (beat) begin
          // beats past capacity are swallowed until the frame ends
          if (cnt_q < MAX_C) begin
            buf_d[cnt_q] = host.host_data;
            cnt_d        = cnt_q + 1'b1;
            v_beat       = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = host.host_last ? CHECK : LOAD;
        end
      end
      CHECK: begin
        if (ovf_q || v_err) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
        end else begin
          state_d    = SEND;
          in_valid_d = 1'b1;
          data_d     = buf_q[0];
          idx_d      = CNT_W'(1);
        end
      end
      SEND: begin
        perr_d = perr_q | chk_out_valid;
        if (idx_q < cnt_q) begin
          in_valid_d = 1'b1;
          data_d     = buf_q[idx_q];
          idx_d      = idx_q + 1'b1;
        end else if (perr_d) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
        end else begin
          state_d = WAIT;
`ifdef FEEDER_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      WAIT: begin
        if (chk_out_valid) begin
          state_d       = REPORT;
          done_valid_d  = 1'b1;
          done_result_d = chk_result;
`ifdef FEEDER_WATCHDOG_EN
        end else if (wd_q == WD_W'(WD_CYCLES - 1)) begin
          state_d      = REPORT;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      REPORT: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        ovf_d   = 1'b0;
        perr_d  = 1'b0;
        v_clr   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      buf_q         <= '{default: '0};
      ovf_q         <= 1'b0;
      perr_q        <= 1'b0;
      in_valid_q    <= 1'b0;
      data_q        <= '0;
      done_valid_q  <= 1'b0;
      done_result_q <= 1'b0;
      done_err_q    <= 1'b0;
`ifdef FEEDER_WATCHDOG_EN
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      ovf_q         <= ovf_d;
      perr_q        <= perr_d;
      in_valid_q    <= in_valid_d;
      data_q        <= data_d;
      done_valid_q  <= done_valid_d;
      done_result_q <= done_result_d;
      done_err_q    <= done_err_d;
`ifdef FEEDER_WATCHDOG_EN
      wd_q          <= wd_d;
`endif
    end
  end

  assign in_valid    = in_valid_q;
  assign data        = data_q;
  assign done_valid  = done_valid_q;
  assign done_result = done_result_q;
  assign done_err    = done_err_q;

endmodule

// File: tb/tb_train_seq_feeder.sv
// Self-checking bench for train_seq_feeder: vector table,
// hand-written corner sequences and randomized frames vs a model.
module tb_train_seq_feeder;

  localparam int MAXC = 10;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data;
  logic       chk_out_valid;
  logic       chk_result;
  logic       done_valid;
  logic       done_result;
  logic       done_err;

  train_seq_feeder_if #(.DATA_W(4)) h();

  train_seq_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (h),
    .in_valid      (in_valid),
    .data          (data),
    .chk_out_valid (chk_out_valid),
    .chk_result    (chk_result),
    .done_valid    (done_valid),
    .done_result   (done_result),
    .done_err      (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int v [12];
    bit verdict;
    bit f_ok;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last, t_first, t_done, t_chk, t_end;
  bit got_done, o_res, o_err;
  int obs [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // sample point is 1 time unit after each rising edge
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_frame(input int q [$]);
    foreach (q[i]) begin
      h.host_valid = 1'b1;
      h.host_data  = 4'(q[i]);
      h.host_last  = (i == q.size() - 1);
      chk("host_ready", h.host_ready, 1);
      tick;
    end
    t_last       = cyc;
    h.host_valid = 1'b0;
    h.host_last  = 1'b0;
    h.host_data  = '0;
  endtask

  // mode 0: answer after burst, 1: strobe during burst, 2: silent
  task automatic observe(input bit verdict, input int dly,
                         input int mode, input int budget);
    int  wcnt;
    bit  was_v;
    wcnt     = -1;
    was_v    = 1'b0;
    got_done = 1'b0;
    o_res    = 1'b0;
    o_err    = 1'b0;
    t_first  = -1;
    t_done   = -1;
    t_chk    = -1;
    t_end    = -1;
    obs.delete();
    for (int k = 0; k < budget && !got_done; k++) begin
      if (in_valid) begin
        if (t_first < 0) t_first = cyc + 1;
        obs.push_back(int'(data));
      end
      if (done_valid) begin
        got_done = 1'b1;
        t_done   = cyc + 1;
        o_res    = done_result;
        o_err    = done_err;
      end
      chk_out_valid = 1'b0;
      if (mode == 1 && in_valid && obs.size() == 1) begin
        chk_out_valid = 1'b1;
        chk_result    = verdict;
      end
      if (was_v && !in_valid) begin
        t_end = cyc;
        wcnt  = dly;
      end
      if (wcnt == 0 && mode == 0) begin
        chk_out_valid = 1'b1;
        chk_result    = verdict;
        t_chk         = cyc + 1;
      end
      if (wcnt >= 0) wcnt--;
      was_v = in_valid;
      if (!got_done) tick;
    end
    chk_out_valid = 1'b0;
  endtask

  task automatic run_frame(input int q [$], input bit verdict,
                           input int dly, input int mode,
                           input bit f_ok);
    bit e_err;
    e_err = !f_ok || (mode == 1);
    drive_frame(q);
    observe(verdict, dly, mode, 80);
    chk("done_seen", got_done, 1);
    chk("done_err", o_err, e_err);
    chk("done_result", o_res, e_err ? 0 : verdict);
    chk("burst_len", obs.size(), f_ok ? q.size() : 0);
    if (f_ok) begin
      for (int i = 0; i < obs.size() && i < q.size(); i++)
        chk("burst_data", obs[i], q[i]);
      chk("lat_first", t_first, t_last + 2);
    end else begin
      chk("lat_err", t_done, t_last + 2);
    end
    if (f_ok && mode == 0)
      chk("lat_done", t_done, t_chk + 1);
    if (got_done) begin
      tick;
      chk("done_pulse", done_valid, 0);
      chk("idle_ready", h.host_ready, 1);
    end
  endtask

  // frame is a permutation of 1..n with n within capacity
  function automatic bit model_ok(input int q [$]);
    bit used [int];
    if (q.size() > MAXC) return 1'b0;
    foreach (q[i]) begin
      if (q[i] < 1 || q[i] > q.size()) return 1'b0;
      if (used.exists(q[i])) return 1'b0;
      used[q[i]] = 1'b1;
    end
    return 1'b1;
  endfunction

  vec_t tbl [12];

  initial begin
    int q [$];
    int n, j, tmp, nd;

    tbl[0]  = '{3,  '{3,2,1,0,0,0,0,0,0,0,0,0},    1'b1, 1'b1};
    tbl[1]  = '{3,  '{3,1,2,0,0,0,0,0,0,0,0,0},    1'b0, 1'b1};
    tbl[2]  = '{3,  '{1,1,2,0,0,0,0,0,0,0,0,0},    1'b1, 1'b0};
    tbl[3]  = '{11, '{1,2,3,4,5,6,7,8,9,10,1,0},   1'b1, 1'b0};
    tbl[4]  = '{2,  '{2,1,0,0,0,0,0,0,0,0,0,0},    1'b1, 1'b1};
    tbl[5]  = '{1,  '{0,0,0,0,0,0,0,0,0,0,0,0},    1'b1, 1'b0};
    tbl[6]  = '{1,  '{11,0,0,0,0,0,0,0,0,0,0,0},   1'b1, 1'b0};
    tbl[7]  = '{2,  '{1,3,0,0,0,0,0,0,0,0,0,0},    1'b1, 1'b0};
    tbl[8]  = '{1,  '{1,0,0,0,0,0,0,0,0,0,0,0},    1'b0, 1'b1};
    tbl[9]  = '{10, '{10,9,8,7,6,5,4,3,2,1,0,0},   1'b1, 1'b1};
    tbl[10] = '{12, '{1,2,3,4,5,6,7,8,9,10,2,3},   1'b1, 1'b0};
    tbl[11] = '{1,  '{15,0,0,0,0,0,0,0,0,0,0,0},   1'b0, 1'b0};

    h.host_valid  = 1'b0;
    h.host_data   = '0;
    h.host_last   = 1'b0;
    chk_out_valid = 1'b0;
    chk_result    = 1'b0;
    rst_n         = 1'b0;
    tick;
    tick;
    chk("rst_in_valid", in_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_result", done_result, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_host_ready", h.host_ready, 1);
    rst_n = 1'b1;
    tick;

    foreach (tbl[k]) begin
      q.delete();
      for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].v[i]);
      run_frame(q, tbl[k].verdict, k % 3, 0, tbl[k].f_ok);
    end

    // verdict strobe while the burst is still going out
    q = '{2, 1, 3};
    run_frame(q, 1'b1, 0, 1, 1'b1);

    // reset in the middle of a 10-car burst
    q.delete();
    for (int i = 1; i <= 10; i++) q.push_back(i);
    drive_frame(q);
    tick;
    tick;
    tick;
    chk("mid_send_valid", in_valid, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_send_valid", in_valid, 0);
    chk("rst_send_ready", h.host_ready, 1);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_valid || in_valid) nd++;
      tick;
    end
    chk("rst_no_activity", nd, 0);
    q = '{1};
    run_frame(q, 1'b1, 1, 0, 1'b1);

    // randomized frames against the model
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 12);
      q.delete();
      for (int i = 1; i <= n; i++) q.push_back(i);
      for (int i = n - 1; i > 0; i--) begin
        j    = $urandom_range(0, i);
        tmp  = q[i];
        q[i] = q[j];
        q[j] = tmp;
      end
      if ($urandom_range(0, 3) == 0)
        q[$urandom_range(0, n - 1)] = $urandom_range(0, 15);
      run_frame(q, 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), 0, model_ok(q));
    end

    // checker never answers
    q = '{1};
    drive_frame(q);
`ifdef FEEDER_WATCHDOG_EN
    observe(1'b0, 0, 2, train_pkg::WD_CYCLES + 20);
    chk("wd_done_seen", got_done, 1);
    chk("wd_done_err", o_err, 1);
    chk("wd_done_result", o_res, 0);
    chk("wd_latency", t_done, t_end + train_pkg::WD_CYCLES + 1);
    tick;
`else
    observe(1'b0, 0, 2, 1000);
    chk("silent_no_report", got_done, 0);
    chk("silent_burst_len", obs.size(), 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
`endif
    q = '{2, 1};
    run_frame(q, 1'b1, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
